// File: rtl/PARAMS_pkg.sv
// Shared RV32I parameters, opcode encodings, instruction classes and the
// decode-to-execute bundle type.
package PARAMS_pkg;

   localparam int unsigned INSTR_SIZE = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [INSTR_SIZE-1:0] BOOT_ADDR = '0;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      CLS_NOP    = 4'd0,
      CLS_LUI    = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_JAL    = 4'd3,
      CLS_JALR   = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_LOAD   = 4'd6,
      CLS_STORE  = 4'd7,
      CLS_OPIMM  = 4'd8,
      CLS_OP     = 4'd9
   } instr_class_t;

   typedef struct packed {
      logic                  valid;
      logic [INSTR_SIZE-1:0] pc;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [INSTR_SIZE-1:0] imm;
      instr_class_t          cls;
      logic [2:0]            funct3;
      logic                  funct7b5;
      logic                  illegal;
   } dc_bundle_t;

endpackage

// File: rtl/stage_decode_imm_gen.sv
// Combinational RV32I classifier: instruction -> class, immediate, source use.
// Illegal-opcode flagging is compiled in with DECODE_ILLEGAL_TRAP_EN.
module decode_imm_gen
   import PARAMS_pkg::*;
(
   input  logic [INSTR_SIZE-1:0] instr_i,
   output instr_class_t          class_o,
   output logic [INSTR_SIZE-1:0] imm_o,
   output logic                  rs1_used_o,
   output logic                  rs2_used_o,
   output logic                  illegal_o
);

   logic [6:0] opcode;
   assign opcode = instr_i[6:0];

   always_comb begin
      class_o    = CLS_NOP;
      rs1_used_o = 1'b0;
      rs2_used_o = 1'b0;
      illegal_o  = 1'b0;
      case (opcode)
         OPC_LUI:    class_o = CLS_LUI;
         OPC_AUIPC:  class_o = CLS_AUIPC;
         OPC_JAL:    class_o = CLS_JAL;
         OPC_JALR:   begin class_o = CLS_JALR;   rs1_used_o = 1'b1; end
         OPC_BRANCH: begin class_o = CLS_BRANCH; rs1_used_o = 1'b1; rs2_used_o = 1'b1; end
         OPC_LOAD:   begin class_o = CLS_LOAD;   rs1_used_o = 1'b1; end
         OPC_STORE:  begin class_o = CLS_STORE;  rs1_used_o = 1'b1; rs2_used_o = 1'b1; end
         OPC_OPIMM:  begin class_o = CLS_OPIMM;  rs1_used_o = 1'b1; end
         OPC_OP: begin
            class_o    = CLS_OP;
            rs1_used_o = 1'b1;
            rs2_used_o = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (instr_i[31:25] != 7'b0000000 && instr_i[31:25] != 7'b0100000) begin
               class_o    = CLS_NOP;
               rs1_used_o = 1'b0;
               rs2_used_o = 1'b0;
               illegal_o  = 1'b1;
            end
`endif
         end
         default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_o = 1'b1;
`endif
         end
      endcase
   end

   always_comb begin
      imm_o = '0;
      case (class_o)
         CLS_JALR, CLS_LOAD, CLS_OPIMM:
            imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         CLS_STORE:
            imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         CLS_BRANCH:
            imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         CLS_LUI, CLS_AUIPC:
            imm_o = {instr_i[31:12], 12'b0};
         CLS_JAL:
            imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         default:
            imm_o = '0;
      endcase
   end

endmodule

// File: rtl/stage_decode.sv
// RV32I decode stage: field split, load-use scoreboard, decode->EX register.
// Optional illegal-instruction flagging via DECODE_ILLEGAL_TRAP_EN.
module stage_decode
   import PARAMS_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INSTR_SIZE-1:0] instr_i,
   input  logic [INSTR_SIZE-1:0] pc_i,
   input  logic                  instr_valid_i,
   input  logic                  take_br_i,
   input  logic                  stall_ex_i,
   input  logic                  wb_load_done_i,
   input  logic [REG_ADDR_W-1:0] wb_load_rd_i,
   output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
   output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
   output logic                  stall_dc_o,
   output logic                  dc_valid_o,
   output logic [INSTR_SIZE-1:0] dc_pc_o,
   output logic [REG_ADDR_W-1:0] dc_rs1_o,
   output logic [REG_ADDR_W-1:0] dc_rs2_o,
   output logic [REG_ADDR_W-1:0] dc_rd_o,
   output logic [INSTR_SIZE-1:0] dc_imm_o,
   output instr_class_t          dc_class_o,
   output logic [2:0]            dc_funct3_o,
   output logic                  dc_funct7b5_o,
   output logic                  dc_illegal_o
);

   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   instr_class_t          cls;
   logic [INSTR_SIZE-1:0] imm;
   logic                  rs1_used, rs2_used, illegal;
   logic                  hazard;
   logic [NUM_REGS-1:0]   sb_q, sb_d;
   dc_bundle_t            bundle_q, bundle_d;

   assign rd  = instr_i[11:7];
   assign rs1 = instr_i[19:15];
   assign rs2 = instr_i[24:20];
   assign rf_rs1_addr_o = rs1;
   assign rf_rs2_addr_o = rs2;

   decode_imm_gen u_imm_gen (
      .instr_i    (instr_i),
      .class_o    (cls),
      .imm_o      (imm),
      .rs1_used_o (rs1_used),
      .rs2_used_o (rs2_used),
      .illegal_o  (illegal)
   );

   // Registered bits only: a same-cycle writeback clear releases the stall next cycle.
   assign hazard = instr_valid_i &
                   ((rs1_used & (rs1 != '0) & sb_q[rs1]) |
                    (rs2_used & (rs2 != '0) & sb_q[rs2]));

   assign stall_dc_o = (hazard | stall_ex_i) & ~take_br_i;

   always_comb begin
      bundle_d = bundle_q;
      sb_d     = sb_q;
      if (wb_load_done_i)
         sb_d[wb_load_rd_i] = 1'b0;
      if (take_br_i) begin
         bundle_d.valid = 1'b0;
      end else if (!stall_ex_i) begin
         if (hazard) begin
            bundle_d.valid = 1'b0;
            bundle_d.cls   = CLS_NOP;
         end else begin
            bundle_d.valid    = instr_valid_i;
            bundle_d.pc       = pc_i;
            bundle_d.rs1      = rs1;
            bundle_d.rs2      = rs2;
            bundle_d.rd       = rd;
            bundle_d.imm      = imm;
            bundle_d.cls      = cls;
            bundle_d.funct3   = instr_i[14:12];
            bundle_d.funct7b5 = instr_i[30];
            bundle_d.illegal  = illegal;
            // Set after clear so a same-register set/clear leaves the bit set.
            if (instr_valid_i && cls == CLS_LOAD && rd != '0)
               sb_d[rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb_q              <= '0;
         bundle_q.valid    <= 1'b0;
         bundle_q.pc       <= BOOT_ADDR;
         bundle_q.rs1      <= '0;
         bundle_q.rs2      <= '0;
         bundle_q.rd       <= '0;
         bundle_q.imm      <= '0;
         bundle_q.cls      <= CLS_NOP;
         bundle_q.funct3   <= '0;
         bundle_q.funct7b5 <= 1'b0;
         bundle_q.illegal  <= 1'b0;
      end else begin
         sb_q     <= sb_d;
         bundle_q <= bundle_d;
      end
   end

   assign dc_valid_o    = bundle_q.valid;
   assign dc_pc_o       = bundle_q.pc;
   assign dc_rs1_o      = bundle_q.rs1;
   assign dc_rs2_o      = bundle_q.rs2;
   assign dc_rd_o       = bundle_q.rd;
   assign dc_imm_o      = bundle_q.imm;
   assign dc_class_o    = bundle_q.cls;
   assign dc_funct3_o   = bundle_q.funct3;
   assign dc_funct7b5_o = bundle_q.funct7b5;
   assign dc_illegal_o  = bundle_q.illegal;

endmodule

// File: doc/stage_decode.md
Name: stage_decode

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Takes the fetched instruction, its PC and the fetch valid flag, and splits the RV32I instruction into its fields.
- Generates the sign-extended immediate and drives the register-file read addresses.
- Detects load-use hazards with an in-flight-load scoreboard and registers a decoded bundle for the execute stage.
- Stalls fetch on a hazard and flushes on a taken branch.

Parameters:
- INSTR_SIZE, 32, instruction/PC width (from PARAMS_pkg)
- NUM_REGS, 32, architectural registers; x0 is hardwired zero
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_i  in  INSTR_SIZE  instruction from fetch
- pc_i  in  INSTR_SIZE  PC of instr_i
- instr_valid_i  in  1  instr_i/pc_i valid
- take_br_i  in  1  taken branch/jump resolved in EX; flush
- stall_ex_i  in  1  downstream stall (e.g. memory busy)
- wb_load_done_i  in  1  a load writes back this cycle
- wb_load_rd_i  in  REG_ADDR_W  destination of that load
- rf_rs1_addr_o  out  REG_ADDR_W  regfile read port 1 address (combinational)
- rf_rs2_addr_o  out  REG_ADDR_W  regfile read port 2 address (combinational)
- stall_dc_o  out  1  hazard or downstream stall; fetch holds its PC
- dc_valid_o  out  1  bundle valid to EX
- dc_pc_o  out  INSTR_SIZE  registered PC
- dc_rs1_o, dc_rs2_o, dc_rd_o  out  REG_ADDR_W  registered register indices
- dc_imm_o  out  INSTR_SIZE  registered sign-extended immediate
- dc_class_o  out  4  instr_class_t
- dc_funct3_o  out  3  funct3
- dc_funct7b5_o  out  1  instr[30]
- dc_illegal_o  out  1  illegal opcode (see Optional Feature)

Behaviour:
- Reset: dc_valid_o=0, dc_pc_o=BOOT_ADDR, dc_class_o=CLS_NOP, every other dc_* output 0, scoreboard all 0, stall_dc_o=0.
- Field decode (combinational):
  - opcode=instr[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
  - rf_rs*_addr_o follow instr_i directly.
- Immediate by class:
  - I: sext [31:20]
  - S: sext {[31:25],[11:7]}
  - B: sext {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: sext {[31],[19:12],[20],[30:21],0}
  - R and NOP classes: 0.
- Class map:
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP.
  - Any other opcode decodes as CLS_NOP.
- Source-use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OPIMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
  - x0 is never a hazard.
- Scoreboard: NUM_REGS-bit register of pending loads.
  - Hazard when instr_valid_i and a used source has its scoreboard bit set.
  - The check uses the registered bits only; a clear arriving in the same cycle does not release the stall until the next cycle.
- stall_dc_o = (hazard | stall_ex_i) & ~take_br_i.
- Register update, per cycle:
  - take_br_i: dc_valid_o<=0 and the bundle is not issued. This has priority over stall.
  - else stall_ex_i: the bundle holds unchanged.
  - else hazard: a bubble is inserted (dc_valid_o<=0, dc_class_o<=CLS_NOP).
  - else: the bundle loads from the decode logic and dc_valid_o<=instr_valid_i.
- Scoreboard set: the bit for rd is set on issue of a valid, non-flushed LOAD with rd!=0.
- Scoreboard clear: wb_load_done_i clears bit wb_load_rd_i.
- Set and clear of the same register in one cycle: set wins.
- Latency: 1 cycle from instr_i to the dc_* outputs.
- Reset mid-operation: everything returns to reset values at the next edge, including any pending scoreboard bits.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- With the macro:
  - An unknown opcode, or OP with funct7 not in {0000000,0100000}, sets dc_illegal_o=1 with the bundle.
  - The instruction is issued valid with class CLS_NOP so EX can trap.
- Without the macro:
  - dc_illegal_o is tied to 0.
  - Unknown opcodes issue as CLS_NOP with dc_valid_o following instr_valid_i.

Decomposition:
- Add to PARAMS_pkg:
  - instr_class_t enum (CLS_NOP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP).
  - RV32I opcode localparams.
  - REG_ADDR_W.
- One sub-module, decode_imm_gen: a combinational instruction→{class, imm, rs1_used, rs2_used} block.
- The scoreboard and pipeline register stay in stage_decode.

Test Plan:
- ADDI x1,x0,5 (0x00500093) valid, pc=0x100 → next cycle dc_valid_o=1, dc_class_o=OPIMM, dc_rd_o=1, dc_imm_o=5, dc_pc_o=0x100.
- BEQ with imm=-8 (0xFE000CE3) → dc_imm_o=0xFFFFFFF8, class BRANCH; SW with offset 0x7FF → dc_imm_o=0x7FF.
- LW x5 issued, then ADD x6,x5,x1 next → stall_dc_o=1 and bubble issued every cycle until wb_load_done_i with rd=5, stall deasserted one cycle after the clear, ADD issued.
- LW x0 followed by a use of x0 → no stall; scoreboard stays 0.
- take_br_i asserted during a hazard stall → stall_dc_o=0, dc_valid_o=0 next cycle; take_br_i together with stall_ex_i → flush wins.
- Opcode 0x7F with DECODE_ILLEGAL_TRAP_EN → dc_illegal_o=1, dc_valid_o=1; without the macro → dc_illegal_o=0.
